// File: rtl/axis_m_pkg.sv
// Shared state encoding and width helpers for the packetising AXI4-Stream master.
// The optional tkeep path is enabled with the AXIS_M_PKT_TKEEP_EN macro in the top.
package axis_m_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Occupancy counters need one extra bit to represent a completely full buffer.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int keep_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and synchronous active-high reset.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module axis_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign full    = (r_count == LVL_W'(DEPTH));
    assign empty   = (r_count == '0);
    assign level   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    assign w_pop  = rd_en && !empty;
    assign w_push = wr_en && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LVL_W'(1);
                2'b01:   r_count <= r_count - LVL_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/axis_m_pkt.sv
// AXI4-Stream master that buffers user words and emits them as pkt_len-beat packets.
// Define AXIS_M_PKT_TKEEP_EN to carry a per-byte keep mask alongside the data.
module axis_m_pkt
    import axis_m_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int LEN_W  = 8
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [DATA_W-1:0]          wr_data,
`ifdef AXIS_M_PKT_TKEEP_EN
    input  logic [keep_w(DATA_W)-1:0]  wr_keep,
`endif
    input  logic                       wr_en,
    output logic                       full,
    output logic [level_w(DEPTH)-1:0]  level,
    input  logic                       send,
    input  logic [LEN_W-1:0]           pkt_len,
    output logic                       busy,
    input  logic                       tready,
    output logic                       tvalid,
    output logic [DATA_W-1:0]          tdata,
`ifdef AXIS_M_PKT_TKEEP_EN
    output logic [keep_w(DATA_W)-1:0]  tkeep,
`endif
    output logic                       tlast,
    output logic                       finish
);

    localparam int KW = keep_w(DATA_W);
`ifdef AXIS_M_PKT_TKEEP_EN
    localparam int FW = DATA_W + KW;
`else
    localparam int FW = DATA_W;
`endif

    state_t            r_state;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_tvalid;
    logic [DATA_W-1:0] r_tdata;
    logic              r_tlast;
    logic              r_finish;
`ifdef AXIS_M_PKT_TKEEP_EN
    logic [KW-1:0]     r_tkeep;
`endif

    logic [FW-1:0]     w_fifo_wr;
    logic [FW-1:0]     w_head;
    logic              w_empty;
    logic              w_hs;
    logic              w_load;

`ifdef AXIS_M_PKT_TKEEP_EN
    assign w_fifo_wr = {wr_keep, wr_data};
    assign tkeep     = r_tkeep;
`else
    assign w_fifo_wr = wr_data;
`endif

    assign w_hs = r_tvalid && tready;

    // r_remaining counts beats not yet loaded into the output register.
    assign w_load = (r_state == SEND) && (!r_tvalid || w_hs)
                    && (r_remaining != '0) && !w_empty;

    axis_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (aclk),
        .rst     (areset),
        .wr_data (w_fifo_wr),
        .wr_en   (wr_en),
        .rd_en   (w_load),
        .rd_data (w_head),
        .full    (full),
        .empty   (w_empty),
        .level   (level)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_finish    <= 1'b0;
`ifdef AXIS_M_PKT_TKEEP_EN
            r_tkeep     <= '0;
`endif
        end else begin
            r_finish <= 1'b0;
            if (r_state == IDLE) begin
                if (send && (pkt_len != '0)) begin
                    r_state     <= SEND;
                    r_remaining <= pkt_len;
                end
            end else if (w_hs && r_tlast) begin
                r_state  <= IDLE;
                r_finish <= 1'b1;
            end

            if (w_load) begin
                r_tvalid    <= 1'b1;
                r_tdata     <= w_head[DATA_W-1:0];
                r_tlast     <= (r_remaining == LEN_W'(1));
                r_remaining <= r_remaining - LEN_W'(1);
`ifdef AXIS_M_PKT_TKEEP_EN
                r_tkeep     <= w_head[DATA_W +: KW];
`endif
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
                r_tdata  <= '0;
                r_tlast  <= 1'b0;
`ifdef AXIS_M_PKT_TKEEP_EN
                r_tkeep  <= '0;
`endif
            end
        end
    end

    assign busy   = (r_state == SEND);
    assign tvalid = r_tvalid;
    assign tdata  = r_tdata;
    assign tlast  = r_tlast;
    assign finish = r_finish;

endmodule

// File: tb/tb_axis_m_pkt.sv
// Self-checking bench for axis_m_pkt: queue-based reference model compared every
// cycle, directed packet scenarios with literal expectations, then random traffic.
module tb_axis_m_pkt;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int LW    = 8;
    localparam int KW    = DW / 8;
    localparam int QW    = DW + KW;

    logic          aclk    = 1'b0;
    logic          areset  = 1'b1;
    logic          wr_en   = 1'b0;
    logic          send    = 1'b0;
    logic          tready  = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [LW-1:0] pkt_len = '0;
    logic          full;
    logic          busy;
    logic          tvalid;
    logic          tlast;
    logic          finish;
    logic [4:0]    level;
    logic [DW-1:0] tdata;
`ifdef AXIS_M_PKT_TKEEP_EN
    logic [KW-1:0] wr_keep = '0;
    logic [KW-1:0] tkeep;
`endif

    int n_vec  = 0;
    int n_err  = 0;
    int n_fin  = 0;
    bit chk_en = 1'b0;

    logic [DW:0] got_q[$];
    logic [DW:0] exp_q[$];

    axis_m_pkt #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .LEN_W  (LW)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .wr_data (wr_data),
`ifdef AXIS_M_PKT_TKEEP_EN
        .wr_keep (wr_keep),
`endif
        .wr_en   (wr_en),
        .full    (full),
        .level   (level),
        .send    (send),
        .pkt_len (pkt_len),
        .busy    (busy),
        .tready  (tready),
        .tvalid  (tvalid),
        .tdata   (tdata),
`ifdef AXIS_M_PKT_TKEEP_EN
        .tkeep   (tkeep),
`endif
        .tlast   (tlast),
        .finish  (finish)
    );

    // clock / reset
    always #5 aclk = ~aclk;

    task automatic cyc();
        @(negedge aclk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: FIFO as a queue, a packet as "beats still to load"
    logic [QW-1:0] m_q[$];
    bit            m_busy   = 1'b0;
    bit            m_tvalid = 1'b0;
    bit            m_tlast  = 1'b0;
    bit            m_finish = 1'b0;
    logic [DW-1:0] m_tdata  = '0;
    logic [KW-1:0] m_tkeep  = '0;
    int            m_rem    = 0;

    always @(posedge aclk) begin
        bit            hs;
        bit            ld;
        bit            old_busy;
        bit            old_last;
        logic [QW-1:0] head;
        logic [KW-1:0] kin;
        kin = '0;
`ifdef AXIS_M_PKT_TKEEP_EN
        kin = wr_keep;
`endif
        if (areset) begin
            m_q.delete();
            m_busy   = 1'b0;
            m_tvalid = 1'b0;
            m_tlast  = 1'b0;
            m_finish = 1'b0;
            m_tdata  = '0;
            m_tkeep  = '0;
            m_rem    = 0;
        end else begin
            hs       = m_tvalid && tready;
            old_busy = m_busy;
            old_last = m_tlast;
            ld       = old_busy && (!m_tvalid || hs) && (m_rem > 0) && (m_q.size() > 0);
            m_finish = 1'b0;
            if (ld) begin
                head     = m_q.pop_front();
                m_tvalid = 1'b1;
                m_tdata  = head[DW-1:0];
                m_tkeep  = head[DW +: KW];
                m_tlast  = (m_rem == 1);
                m_rem    = m_rem - 1;
            end else if (hs) begin
                m_tvalid = 1'b0;
                m_tdata  = '0;
                m_tkeep  = '0;
                m_tlast  = 1'b0;
            end
            // a pop earlier this cycle frees the slot, so push-while-full-and-popping is kept
            if (wr_en && (m_q.size() < DEPTH)) m_q.push_back({kin, wr_data});
            if (!old_busy) begin
                if (send && (pkt_len != 0)) begin
                    m_busy = 1'b1;
                    m_rem  = int'(pkt_len);
                end
            end else if (hs && old_last) begin
                m_busy   = 1'b0;
                m_finish = 1'b1;
            end
        end
    end

    // compare process
    always @(negedge aclk) begin
        if (chk_en) begin
            chk("tvalid", tvalid, m_tvalid);
            chk("tdata",  tdata,  m_tdata);
            chk("tlast",  tlast,  m_tlast);
            chk("finish", finish, m_finish);
            chk("busy",   busy,   m_busy);
            chk("level",  level,  m_q.size());
            chk("full",   full,   m_q.size() == DEPTH);
`ifdef AXIS_M_PKT_TKEEP_EN
            chk("tkeep",  tkeep,  m_tkeep);
`endif
        end
        if (finish === 1'b1) n_fin++;
    end

    // beat capture on every handshake
    always @(posedge aclk) begin
        if (areset === 1'b0 && tvalid === 1'b1 && tready === 1'b1)
            got_q.push_back({tlast, tdata});
    end

    // driver tasks
    task automatic push(input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
`ifdef AXIS_M_PKT_TKEEP_EN
        wr_keep = KW'($urandom);
`endif
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic start(input int len);
        send    = 1'b1;
        pkt_len = LW'(len);
        cyc();
        send = 1'b0;
    endtask

    task automatic wait_finish(input int budget, output int n);
        n = 0;
        while (finish !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        chk("finish_seen", finish, 1);
    endtask

    task automatic cmp_beats(input string nm);
        chk({nm, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk(nm, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int         n;
        int         f0;
        logic [3:0] pat;
        logic [DW-1:0] fill[17];
        pat = 4'b1001;

        cyc();
        cyc();
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata",  tdata,  0);
        chk("rst_tlast",  tlast,  0);
        chk("rst_finish", finish, 0);
        chk("rst_busy",   busy,   0);
        chk("rst_full",   full,   0);
        chk("rst_level",  level,  0);
        chk_en = 1'b1;
        areset = 1'b0;
        cyc();

        // four-beat packet, tready held high
        got_q.delete();
        tready = 1'b1;
        f0 = n_fin;
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        start(4);
        wait_finish(40, n);
        chk("t1_latency", n, 5);
        chk("t1_level", level, 0);
        cyc();
        chk("t1_fin_count", n_fin - f0, 1);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 32'hA0 + 32'(i)});
        cmp_beats("t1_beat");

        // same packet under 1,0,0,1 backpressure
        tready = 1'b0;
        f0 = n_fin;
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        start(4);
        for (int i = 0; i < 60 && finish !== 1'b1; i++) begin
            tready = pat[i % 4];
            cyc();
        end
        chk("t2_finish", finish, 1);
        tready = 1'b1;
        cyc();
        chk("t2_fin_count", n_fin - f0, 1);
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3), 32'hA0 + 32'(i)});
        cmp_beats("t2_beat");

        // send with FIFO empty, data trickles in
        f0 = n_fin;
        start(3);
        for (int i = 1; i <= 3; i++) begin
            push(32'(i));
            cyc();
        end
        wait_finish(20, n);
        cyc();
        chk("t3_fin_count", n_fin - f0, 1);
        for (int i = 1; i <= 3; i++) exp_q.push_back({(i == 3), 32'(i)});
        cmp_beats("t3_beat");

        // fill, drop the 17th, then push and pop together while full
        tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            fill[i] = 32'h100 + 32'(i);
            push(fill[i]);
        end
        push(32'hDEAD);
        chk("t4_full", full, 1);
        chk("t4_level_full", level, 16);
        start(17);
        fill[16] = 32'hBEEF;
        push(fill[16]);
        chk("t4_level_pushpop", level, 16);
        chk("t4_full_pushpop", full, 1);
        tready = 1'b1;
        wait_finish(60, n);
        cyc();
        for (int i = 0; i < 17; i++) exp_q.push_back({(i == 16), fill[i]});
        cmp_beats("t4_beat");

        // ignored sends: zero length, and while busy
        f0 = n_fin;
        start(0);
        cyc();
        chk("t5_len0_busy", busy, 0);
        chk("t5_len0_tvalid", tvalid, 0);
        tready = 1'b0;
        push(32'h55);
        push(32'h66);
        start(2);
        cyc();
        cyc();
        start(5);
        tready = 1'b1;
        wait_finish(20, n);
        repeat (4) cyc();
        chk("t5_busy_after", busy, 0);
        chk("t5_tvalid_after", tvalid, 0);
        chk("t5_fin_count", n_fin - f0, 1);
        exp_q.push_back({1'b0, 32'h55});
        exp_q.push_back({1'b1, 32'h66});
        cmp_beats("t5_beat");

        // reset during beat 2 of a 5-beat packet
        for (int i = 0; i < 5; i++) push(32'hC0 + 32'(i));
        f0 = n_fin;
        start(5);
        cyc();
        cyc();
        areset = 1'b1;
        cyc();
        chk("t6_tvalid", tvalid, 0);
        chk("t6_level", level, 0);
        chk("t6_busy", busy, 0);
        chk("t6_finish", finish, 0);
        areset = 1'b0;
        repeat (4) cyc();
        chk("t6_no_finish", n_fin - f0, 0);
        got_q.delete();

        // random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            wr_en   = ($urandom_range(0, 99) < 55);
            wr_data = $urandom;
`ifdef AXIS_M_PKT_TKEEP_EN
            wr_keep = KW'($urandom);
`endif
            tready  = ($urandom_range(0, 99) < 70);
            send    = ($urandom_range(0, 9) == 0);
            pkt_len = ($urandom_range(0, 9) == 0) ? LW'($urandom_range(8, 20))
                                                  : LW'($urandom_range(0, 6));
            areset  = ($urandom_range(0, 499) == 0);
            cyc();
        end
        areset = 1'b0;
        send   = 1'b0;
        tready = 1'b1;
        for (int c = 0; c < 200 && busy !== 1'b0; c++) begin
            wr_en   = 1'b1;
            wr_data = $urandom;
            cyc();
        end
        wr_en = 1'b0;
        repeat (3) cyc();
        chk("drain_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_m_pkt.md
Name: axis_m_pkt

Overview:
Parametrised AXI4-Stream master that buffers user words in an internal synchronous FIFO and emits them as multi-beat packets.
- A `send` pulse starts a packet of `pkt_len` beats. `tlast` marks the final beat. `finish` pulses after the last handshake.
- Successor to the single-beat stream master. Adds configurable data width, buffer depth, packet length, and backpressure-safe streaming.
- Sits between a user/test-pattern source and any AXIS slave in the design.

Parameters:
DATA_W, 32, tdata / wr_data width in bits (multiple of 8)
DEPTH, 16, FIFO depth in words (power of 2, >=2)
LEN_W, 8, width of the packet-length field; max packet = 2^LEN_W-1 beats

Ports:
aclk  in  1  clock, all logic on rising edge
areset  in  1  synchronous active-high reset
wr_data  in  DATA_W  word to buffer
wr_en  in  1  push wr_data into FIFO this cycle
full  out  1  FIFO full; pushes while full are dropped
level  out  $clog2(DEPTH)+1  FIFO occupancy
send  in  1  start packet (sampled only in IDLE)
pkt_len  in  LEN_W  beats in packet, latched on accepted send
busy  out  1  high in SEND state
tready  in  1  AXIS slave ready
tvalid  out  1  AXIS valid (registered)
tdata  out  DATA_W  AXIS data (registered)
tlast  out  1  high with final beat of packet (registered)
finish  out  1  one-cycle pulse after last beat handshake

Behaviour:
- Reset values: tvalid=0, tdata=0, tlast=0, finish=0, busy=0, full=0, level=0. FIFO is flushed.
- Reset asserted mid-packet: packet is abandoned, FIFO flushed, no finish pulse, FSM returns to IDLE.
- Handshake: `hs = tvalid & tready`.
- Once tvalid=1, tvalid, tdata and tlast hold stable until hs. tvalid never drops without hs.
- FSM has two states, IDLE and SEND.
  - IDLE: `send=1 && pkt_len!=0` at edge N → SEND. Latch `remaining=pkt_len`.
  - IDLE: `send` with `pkt_len==0` is ignored.
  - SEND: `send` is ignored.
- Output register: at each edge in SEND, load the FIFO head into tdata, set tvalid=1 and pop, when all of the following hold:
  - the output register is empty, or hs occurs this cycle;
  - `remaining>0` (counting beats not yet loaded);
  - FIFO not empty.
- On that load, decrement `remaining`. tlast=1 when the loaded beat is the final one (`remaining==1` before decrement).
- On hs without a new load, tvalid=0 and tdata=0.
- Latency:
  - send accepted at edge N with data present → tvalid=1 after edge N+1.
  - FIFO empty mid-packet → tvalid=0 (gap) until data arrives. The loaded beat appears 1 cycle after the push.
- Throughput: with tready held high and FIFO non-empty, 1 beat per cycle.
- Last beat: hs with tlast=1 → state IDLE and finish=1 for exactly one cycle. A new send is accepted from the next cycle.
- FIFO:
  - Push when `wr_en && !full`. Pop as above.
  - Simultaneous push and pop while full is allowed: level is unchanged, no data lost.
  - Pointers wrap modulo DEPTH.
  - `level` and `full` update the cycle after the edge.
- Words left in the FIFO after a packet remain for the next packet.

Optional Feature:
AXIS_M_PKT_TKEEP_EN
- Defined: adds input `wr_keep[DATA_W/8]` and output `tkeep[DATA_W/8]`.
  - wr_keep is stored in the FIFO alongside wr_data and follows tdata timing exactly.
  - tkeep resets to 0 and clears to 0 on hs without load.
- Undefined: no keep ports, FIFO width is DATA_W.

Decomposition:
- Package `axis_m_pkg` holds:
  - the FSM state encoding (IDLE=1'b0, SEND=1'b1);
  - the `clog2`-based width helper;
  - the keep-width constant `DATA_W/8`.
- One sub-module, `axis_sync_fifo` (parameters: width, depth). Provides show-ahead head data, full/empty/level and synchronous active-high reset; reused by later stream blocks.

Test Plan:
- Push 4 words 0xA0..0xA3, send with pkt_len=4, tready=1 → tvalid high from edge N+1 for 4 consecutive cycles; tdata A0,A1,A2,A3; tlast only with A3; finish pulse 1 cycle after A3 hs; level=0.
- Same packet with tready toggling 1,0,0,1,... → tdata/tvalid/tlast held stable during tready=0; no beat duplicated or skipped.
- send pkt_len=3 with FIFO empty, push words 1 cycle apart → tvalid gaps between beats; beats in order; tlast on the 3rd; one finish.
- Fill to DEPTH=16, push 17th (dropped, full=1); then push and pop in the same cycle while full → level stays 16; all 16 originals plus the simultaneous push emerge in order.
- send with pkt_len=0, and send while busy → no state change, no extra tvalid or finish.
- Assert areset during beat 2 of a 5-beat packet → next cycle tvalid=0, level=0, busy=0; no finish pulse.
